ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Converts the byte stream from the PS/2 receiver into the synth control signals consumed by the IO controller.
- Signals produced: note gate, note index, octave +/- pulses, ADSR selector, ADSR +/- pulses.
- Parses set-2 make, break (F0) and extended (E0) sequences.
- Tracks held keys, so that typematic repeats never retrigger pulses and the note gate follows physical key state.

Parameters:
- PREFIX_TIMEOUT, 2500000, clk cycles a pending E0/F0 prefix may wait for its next byte before the parser aborts to IDLE (50 ms at 50 MHz).
- CNT_W, 22, width of the timeout counter; must hold PREFIX_TIMEOUT.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-low reset
- byte_valid  in  1  one-cycle strobe: byte_data holds a new received byte
- byte_data  in  8  received scan-code byte
- byte_error  in  1  one-cycle strobe: receiver framing/parity error
- note_in  out  1  high while any note key is held
- note  out  4  current note index 0..11 (C..B)
- octave_plus_plus  out  1  one-cycle pulse
- octave_minus_minus  out  1  one-cycle pulse
- ADSR_selector  out  3  selected parameter 0..4
- ADSR_plus_plus  out  1  one-cycle pulse
- ADSR_minus_minus  out  1  one-cycle pulse

Behaviour:
- Key map (set 2), note keys: A=1C→0, W=1D→1, S=1B→2, E=24→3, D=23→4, F=2B→5, T=2C→6, G=34→7, Y=35→8, H=33→9, U=3C→10, J=3B→11.
- Key map, other keys: Z=1A octave−, X=22 octave+, keys 1..5 (16,1E,26,25,2E) set selector 0..4, E0 75 (up) ADSR+, E0 72 (down) ADSR−.
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK. All transitions occur only on byte_valid.
- E0 byte: from any state → EXT.
- F0 byte: IDLE→BRK, EXT→EXT_BRK; BRK and EXT_BRK stay unchanged.
- Other bytes: IDLE = make, EXT = extended make, BRK = break, EXT_BRK = extended break. After processing, the FSM returns to IDLE.
- Codes not in the map, including a plain code arriving in EXT or an extended code arriving in IDLE, are ignored and the FSM returns to IDLE.
- Timeout counter: clears on each byte_valid and counts while the FSM is not in IDLE. On reaching PREFIX_TIMEOUT the FSM goes to IDLE and the pending prefix is dropped.
- byte_error → IDLE, pending byte dropped. This takes priority over a byte_valid in the same cycle.
- held_notes[11:0]: make sets the bit, break clears it. note_in = |held_notes, registered.
- last_note register: loaded on a note make.
- note output: last_note if that key is still held; otherwise the lowest-index held note. When nothing is held, note keeps its previous value.
- Held flags for Z, X, up, down: set on make, cleared on break.
- A pulse fires only on a make while the key's held flag is 0. Typematic repeats produce no pulse. A break never pulses.
- ADSR_selector loads on a make of keys 1..5; repeats are harmless.
- All outputs are registered. Latency: outputs change on the clk edge after the byte_valid cycle of the final byte of a sequence, i.e. 1 cycle.
- Each pulse is high exactly one cycle. Pulses from different sequences never overlap, since one byte completes at most one sequence.
- Reset (reset=0) on a clk edge, including mid-sequence:
  - FSM → IDLE; counter, held_notes and held flags cleared.
  - note_in=0, note=0, last_note=0, ADSR_selector=0, all pulses 0.
- Break of a key that is not held: no effect. Make of an already-held note: last_note is updated, nothing else changes.

Test Plan:
- Bytes 1C, then F0 1C → note_in=1 and note=0 one cycle after 1C; note_in=0 one cycle after the final 1C; note stays 0.
- Bytes 1C, 23, F0 23 → note=0, then 4, then falls back to 0 with note_in still 1. Then F0 1C → note_in=0.
- Bytes 22 22 22 then F0 22, then 22 → octave_plus_plus pulses exactly twice (first 22 and the 22 after the break), each 1 cycle wide.
- Bytes E0 75, E0 75, E0 F0 75, E0 72 → one ADSR_plus_plus pulse, then one ADSR_minus_minus pulse. Byte 26 → ADSR_selector=2.
- Byte F0, then PREFIX_TIMEOUT idle cycles, then 1C → 1C is treated as a make: note_in=1 (break prefix dropped).
- Bytes 1C then E0 with reset asserted one cycle before the next byte 75 → all outputs 0 after reset. Following 75 (no prefix) is ignored: no ADSR pulse, note_in stays 0.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns the scan-code byte stream coming out of the PS/2 receiver into the
// control signals the synth IO controller expects. Set-2 make, break (F0) and
// extended (E0) sequences are parsed. Held keys are tracked so that typematic
// repeats never retrigger a pulse, and so that the note gate follows the
// physical state of the keys.
//
// Ports:
//   clk                 system clock
//   reset               synchronous, active-low reset
//   byte_valid          one-cycle strobe, byte_data holds a new byte
//   byte_data[7:0]      received scan-code byte
//   byte_error          one-cycle strobe, receiver framing/parity error
//   note_in             high while any note key is held
//   note[3:0]           current note index 0..11 (C..B)
//   octave_plus_plus    one-cycle pulse on a fresh X press
//   octave_minus_minus  one-cycle pulse on a fresh Z press
//   ADSR_selector[2:0]  selected envelope parameter 0..4 (keys 1..5)
//   ADSR_plus_plus      one-cycle pulse on a fresh cursor-up press
//   ADSR_minus_minus    one-cycle pulse on a fresh cursor-down press
module ps2_key_decoder #(
  parameter int PREFIX_TIMEOUT = 2500000,
  parameter int CNT_W          = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_error,
  output logic       note_in,
  output logic [3:0] note,
  output logic       octave_plus_plus,
  output logic       octave_minus_minus,
  output logic [2:0] ADSR_selector,
  output logic       ADSR_plus_plus,
  output logic       ADSR_minus_minus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(PREFIX_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [11:0]       held_notes_q, held_notes_d;
  logic [3:0]        last_note_q, last_note_d;
  logic              z_held_q, z_held_d;
  logic              x_held_q, x_held_d;
  logic              up_held_q, up_held_d;
  logic              dn_held_q, dn_held_d;
  logic              note_in_q, note_in_d;
  logic [3:0]        note_q, note_d;
  logic [2:0]        sel_q, sel_d;
  logic              oct_plus_q, oct_plus_d;
  logic              oct_minus_q, oct_minus_d;
  logic              adsr_plus_q, adsr_plus_d;
  logic              adsr_minus_q, adsr_minus_d;

  logic              is_ext;
  logic              is_brk;
  logic [4:0]        note_hit;

  // Returns {valid, index} for the twelve note keys.
  function automatic logic [4:0] noteLookup(input logic [7:0] code);
    case (code)
      8'h1C:   return {1'b1, 4'd0};
      8'h1D:   return {1'b1, 4'd1};
      8'h1B:   return {1'b1, 4'd2};
      8'h24:   return {1'b1, 4'd3};
      8'h23:   return {1'b1, 4'd4};
      8'h2B:   return {1'b1, 4'd5};
      8'h2C:   return {1'b1, 4'd6};
      8'h34:   return {1'b1, 4'd7};
      8'h35:   return {1'b1, 4'd8};
      8'h33:   return {1'b1, 4'd9};
      8'h3C:   return {1'b1, 4'd10};
      8'h3B:   return {1'b1, 4'd11};
      default: return 5'd0;
    endcase
  endfunction

  // Scanning downwards leaves the lowest set index as the final answer.
  function automatic logic [3:0] lowestHeld(input logic [11:0] held);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (held[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Parser next state, prefix timeout and key bookkeeping. Only the byte that
  // completes a sequence touches key state; prefixes just move the parser.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    held_notes_d = held_notes_q;
    last_note_d  = last_note_q;
    z_held_d     = z_held_q;
    x_held_d     = x_held_q;
    up_held_d    = up_held_q;
    dn_held_d    = dn_held_q;
    sel_d        = sel_q;
    oct_plus_d   = 1'b0;
    oct_minus_d  = 1'b0;
    adsr_plus_d  = 1'b0;
    adsr_minus_d = 1'b0;
    note_in_d    = note_in_q;
    note_d       = note_q;
    is_ext       = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    is_brk       = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    note_hit     = noteLookup(byte_data);

    if (byte_error) begin
      // A corrupted byte may have been part of a sequence; start over.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (byte_valid) begin
      cnt_d = '0;
      if (byte_data == 8'hE0) begin
        state_d = S_EXT;
      end else if (byte_data == 8'hF0) begin
        if (state_q == S_IDLE)     state_d = S_BRK;
        else if (state_q == S_EXT) state_d = S_EXT_BRK;
      end else begin
        state_d = S_IDLE;
        if (!is_ext) begin
          if (note_hit[4]) begin
            if (is_brk) begin
              held_notes_d[note_hit[3:0]] = 1'b0;
            end else begin
              held_notes_d[note_hit[3:0]] = 1'b1;
              last_note_d                 = note_hit[3:0];
            end
          end
          case (byte_data)
            8'h1A: begin
              if (is_brk) z_held_d = 1'b0;
              else begin
                oct_minus_d = !z_held_q;
                z_held_d    = 1'b1;
              end
            end
            8'h22: begin
              if (is_brk) x_held_d = 1'b0;
              else begin
                oct_plus_d = !x_held_q;
                x_held_d   = 1'b1;
              end
            end
            8'h16:   if (!is_brk) sel_d = 3'd0;
            8'h1E:   if (!is_brk) sel_d = 3'd1;
            8'h26:   if (!is_brk) sel_d = 3'd2;
            8'h25:   if (!is_brk) sel_d = 3'd3;
            8'h2E:   if (!is_brk) sel_d = 3'd4;
            default: ;
          endcase
        end else begin
          case (byte_data)
            8'h75: begin
              if (is_brk) up_held_d = 1'b0;
              else begin
                adsr_plus_d = !up_held_q;
                up_held_d   = 1'b1;
              end
            end
            8'h72: begin
              if (is_brk) dn_held_d = 1'b0;
              else begin
                adsr_minus_d = !dn_held_q;
                dn_held_d    = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end else if (state_q != S_IDLE) begin
      // A prefix left waiting too long means the rest of it was lost.
      if (cnt_q >= TimeoutLast) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // The most recently pressed note wins while it is held; otherwise fall
    // back to the lowest held note, and hold the old value when all are up.
    note_in_d = |held_notes_d;
    if (|held_notes_d) begin
      if (held_notes_d[last_note_d]) note_d = last_note_d;
      else                           note_d = lowestHeld(held_notes_d);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      held_notes_q <= '0;
      last_note_q  <= '0;
      z_held_q     <= 1'b0;
      x_held_q     <= 1'b0;
      up_held_q    <= 1'b0;
      dn_held_q    <= 1'b0;
      note_in_q    <= 1'b0;
      note_q       <= '0;
      sel_q        <= '0;
      oct_plus_q   <= 1'b0;
      oct_minus_q  <= 1'b0;
      adsr_plus_q  <= 1'b0;
      adsr_minus_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      held_notes_q <= held_notes_d;
      last_note_q  <= last_note_d;
      z_held_q     <= z_held_d;
      x_held_q     <= x_held_d;
      up_held_q    <= up_held_d;
      dn_held_q    <= dn_held_d;
      note_in_q    <= note_in_d;
      note_q       <= note_d;
      sel_q        <= sel_d;
      oct_plus_q   <= oct_plus_d;
      oct_minus_q  <= oct_minus_d;
      adsr_plus_q  <= adsr_plus_d;
      adsr_minus_q <= adsr_minus_d;
    end
  end

  assign note_in            = note_in_q;
  assign note               = note_q;
  assign octave_plus_plus   = oct_plus_q;
  assign octave_minus_minus = oct_minus_q;
  assign ADSR_selector      = sel_q;
  assign ADSR_plus_plus     = adsr_plus_q;
  assign ADSR_minus_minus   = adsr_minus_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Self-checking bench for ps2_key_decoder. Directed scenarios use hand-derived
// constants; a randomized byte stream is checked against a key-level model.
module tb_ps2_key_decoder;

  localparam int P = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_error;
  logic       note_in;
  logic [3:0] note;
  logic       octave_plus_plus;
  logic       octave_minus_minus;
  logic [2:0] ADSR_selector;
  logic       ADSR_plus_plus;
  logic       ADSR_minus_minus;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: which physical keys are down, plus pending prefix.
  logic       mHeld [12];
  logic [3:0] mLast;
  logic [3:0] mNote;
  logic       mNoteIn;
  logic [2:0] mSel;
  logic       mZ, mX, mUp, mDn;
  logic       mPendE, mPendF;
  int         mAge;
  logic       eOctP, eOctM, eAdP, eAdM;

  logic [7:0] noteCodes [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                 8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
  logic [7:0] selCodes [5]   = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

  ps2_key_decoder #(.PREFIX_TIMEOUT(P), .CNT_W(22)) dut (
    .clk               (clk),
    .reset             (reset),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_error        (byte_error),
    .note_in           (note_in),
    .note              (note),
    .octave_plus_plus  (octave_plus_plus),
    .octave_minus_minus(octave_minus_minus),
    .ADSR_selector     (ADSR_selector),
    .ADSR_plus_plus    (ADSR_plus_plus),
    .ADSR_minus_minus  (ADSR_minus_minus)
  );

  always #5 clk = ~clk;

  function void modelReset();
    for (int i = 0; i < 12; i++) mHeld[i] = 1'b0;
    mLast = 0; mNote = 0; mNoteIn = 0; mSel = 0;
    mZ = 0; mX = 0; mUp = 0; mDn = 0;
    mPendE = 0; mPendF = 0; mAge = 0;
    eOctP = 0; eOctM = 0; eAdP = 0; eAdM = 0;
  endfunction

  function void modelRefreshNote();
    int lowest;
    lowest = -1;
    for (int i = 11; i >= 0; i--) if (mHeld[i]) lowest = i;
    mNoteIn = (lowest >= 0);
    if (lowest >= 0) mNote = mHeld[mLast] ? mLast : 4'(lowest);
  endfunction

  function void modelByte(input logic [7:0] b);
    logic ext, brk;
    eOctP = 0; eOctM = 0; eAdP = 0; eAdM = 0;
    mAge = 0;
    if (b == 8'hE0) begin
      mPendE = 1; mPendF = 0;
    end else if (b == 8'hF0) begin
      mPendF = 1;
    end else begin
      ext = mPendE; brk = mPendF;
      mPendE = 0; mPendF = 0;
      if (!ext) begin
        for (int i = 0; i < 12; i++) begin
          if (b == noteCodes[i]) begin
            mHeld[i] = !brk;
            if (!brk) mLast = 4'(i);
          end
        end
        for (int i = 0; i < 5; i++) if (b == selCodes[i] && !brk) mSel = 3'(i);
        if (b == 8'h22) begin eOctP = !brk && !mX; mX = !brk; end
        if (b == 8'h1A) begin eOctM = !brk && !mZ; mZ = !brk; end
      end else begin
        if (b == 8'h75) begin eAdP = !brk && !mUp; mUp = !brk; end
        if (b == 8'h72) begin eAdM = !brk && !mDn; mDn = !brk; end
      end
      modelRefreshNote();
    end
  endfunction

  function void modelIdle();
    eOctP = 0; eOctM = 0; eAdP = 0; eAdM = 0;
    if (mPendE || mPendF) begin
      mAge++;
      if (mAge >= P) begin mPendE = 0; mPendF = 0; mAge = 0; end
    end
  endfunction

  function void modelError();
    eOctP = 0; eOctM = 0; eAdP = 0; eAdM = 0;
    mPendE = 0; mPendF = 0; mAge = 0;
  endfunction

  // Drives one clock cycle of input and advances the model to match; outputs
  // are then observed at the following falling edge.
  task automatic step(input logic rstN, input logic v, input logic e, input logic [7:0] b);
    reset = rstN; byte_valid = v; byte_error = e; byte_data = b;
    if (!rstN)  modelReset();
    else if (e) modelError();
    else if (v) modelByte(b);
    else        modelIdle();
    @(negedge clk);
  endtask

  task automatic applyByte(input logic [7:0] b);
    step(1'b1, 1'b1, 1'b0, b);
  endtask

  task automatic applyIdle();
    step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    doReset();
    doReset();
    compared++; if (note_in !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_note_in got=%0b exp=0", note_in); end
    compared++; if (note !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_note got=%0d exp=0", note); end
    compared++; if (ADSR_selector !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_sel got=%0d exp=0", ADSR_selector); end
    compared++;
    if ({octave_plus_plus, octave_minus_minus, ADSR_plus_plus, ADSR_minus_minus} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_pulses got=%b exp=0000",
               {octave_plus_plus, octave_minus_minus, ADSR_plus_plus, ADSR_minus_minus});
    end
  endtask

  task automatic test_note_basic();
    doReset();
    applyByte(8'h1C);
    compared++; if (note_in !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_make_gate got=%0b exp=1", note_in); end
    compared++; if (note !== 4'd0) begin mismatched++; $display("[TB] FAIL basic_make_note got=%0d exp=0", note); end
    applyByte(8'hF0);
    compared++; if (note_in !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_prefix_gate got=%0b exp=1", note_in); end
    applyByte(8'h1C);
    compared++; if (note_in !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_break_gate got=%0b exp=0", note_in); end
    compared++; if (note !== 4'd0) begin mismatched++; $display("[TB] FAIL basic_break_note got=%0d exp=0", note); end
  endtask

  task automatic test_note_fallback();
    doReset();
    applyByte(8'h1C);
    applyByte(8'h23);
    compared++; if (note !== 4'd4) begin mismatched++; $display("[TB] FAIL fallback_second got=%0d exp=4", note); end
    applyByte(8'hF0);
    applyByte(8'h23);
    compared++; if (note !== 4'd0) begin mismatched++; $display("[TB] FAIL fallback_lowest got=%0d exp=0", note); end
    compared++; if (note_in !== 1'b1) begin mismatched++; $display("[TB] FAIL fallback_gate got=%0b exp=1", note_in); end
    applyByte(8'h3B);
    applyByte(8'h23);
    applyByte(8'h1C);
    compared++; if (note !== 4'd0) begin mismatched++; $display("[TB] FAIL fallback_remake got=%0d exp=0", note); end
    applyByte(8'hF0);
    applyByte(8'h1C);
    compared++; if (note !== 4'd4) begin mismatched++; $display("[TB] FAIL fallback_after_last got=%0d exp=4", note); end
    applyByte(8'hF0); applyByte(8'h23);
    applyByte(8'hF0); applyByte(8'h3B);
    compared++; if (note_in !== 1'b0) begin mismatched++; $display("[TB] FAIL fallback_all_up got=%0b exp=0", note_in); end
    compared++; if (note !== 4'd11) begin mismatched++; $display("[TB] FAIL fallback_keep got=%0d exp=11", note); end
  endtask

  task automatic test_octave_repeat();
    logic [7:0] seq [7];
    int pulses;
    seq = '{8'h22, 8'h22, 8'h22, 8'hF0, 8'h22, 8'h22, 8'h00};
    doReset();
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) applyIdle(); else applyByte(seq[i]);
      if (octave_plus_plus === 1'b1) pulses++;
      if (i == 0) begin
        compared++; if (octave_plus_plus !== 1'b1) begin mismatched++; $display("[TB] FAIL octave_first got=%0b exp=1", octave_plus_plus); end
      end
      if (i == 1) begin
        compared++; if (octave_plus_plus !== 1'b0) begin mismatched++; $display("[TB] FAIL octave_width got=%0b exp=0", octave_plus_plus); end
      end
    end
    compared++; if (pulses != 2) begin mismatched++; $display("[TB] FAIL octave_count got=%0d exp=2", pulses); end
    applyByte(8'h1A);
    compared++; if (octave_minus_minus !== 1'b1) begin mismatched++; $display("[TB] FAIL octave_minus got=%0b exp=1", octave_minus_minus); end
  endtask

  task automatic test_adsr();
    int plus, minus;
    logic [7:0] seq [9];
    seq = '{8'hE0, 8'h75, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h72};
    doReset();
    plus = 0; minus = 0;
    for (int i = 0; i < 9; i++) begin
      applyByte(seq[i]);
      if (ADSR_plus_plus === 1'b1) plus++;
      if (ADSR_minus_minus === 1'b1) minus++;
      if (i == 1) begin
        compared++; if (ADSR_plus_plus !== 1'b1) begin mismatched++; $display("[TB] FAIL adsr_up_first got=%0b exp=1", ADSR_plus_plus); end
      end
    end
    compared++; if (ADSR_minus_minus !== 1'b1) begin mismatched++; $display("[TB] FAIL adsr_down got=%0b exp=1", ADSR_minus_minus); end
    compared++; if (plus != 1 || minus != 1) begin mismatched++; $display("[TB] FAIL adsr_counts got=%0d/%0d exp=1/1", plus, minus); end
    applyByte(8'h26);
    compared++; if (ADSR_selector !== 3'd2) begin mismatched++; $display("[TB] FAIL adsr_sel got=%0d exp=2", ADSR_selector); end
    applyByte(8'h75);
    compared++; if (ADSR_plus_plus !== 1'b0) begin mismatched++; $display("[TB] FAIL adsr_plain_75 got=%0b exp=0", ADSR_plus_plus); end
  endtask

  task automatic test_timeout();
    doReset();
    applyByte(8'hF0);
    for (int i = 0; i < P; i++) applyIdle();
    applyByte(8'h1C);
    compared++; if (note_in !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_dropped got=%0b exp=1", note_in); end
    applyByte(8'hF0);
    for (int i = 0; i < P - 1; i++) applyIdle();
    applyByte(8'h1C);
    compared++; if (note_in !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_kept got=%0b exp=0", note_in); end
  endtask

  task automatic test_error();
    doReset();
    applyByte(8'hF0);
    step(1'b1, 1'b1, 1'b1, 8'h1C);
    compared++; if (note_in !== 1'b0) begin mismatched++; $display("[TB] FAIL error_drop got=%0b exp=0", note_in); end
    applyByte(8'h1C);
    compared++; if (note_in !== 1'b1) begin mismatched++; $display("[TB] FAIL error_recover got=%0b exp=1", note_in); end
  endtask

  task automatic test_reset_mid_sequence();
    doReset();
    applyByte(8'h2E);
    applyByte(8'h3B);
    applyByte(8'hE0);
    doReset();
    compared++;
    if ({note_in, note, ADSR_selector} !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs got=%0b/%0d/%0d exp=0/0/0", note_in, note, ADSR_selector);
    end
    applyByte(8'h75);
    compared++; if (ADSR_plus_plus !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_no_ext got=%0b exp=0", ADSR_plus_plus); end
    compared++; if (note_in !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_gate got=%0b exp=0", note_in); end
  endtask

  task automatic test_random();
    int gapLeft, r;
    logic [7:0] b;
    doReset();
    gapLeft = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r = $urandom_range(0, 99);
      if (gapLeft > 0) begin
        gapLeft--;
        applyIdle();
      end else if (r < 1) begin
        doReset();
      end else if (r < 4) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
      end else if (r < 6) begin
        gapLeft = P + 1;
        applyIdle();
      end else if (r < 30) begin
        applyIdle();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 35)      b = noteCodes[$urandom_range(0, 11)];
        else if (r < 47) b = 8'hE0;
        else if (r < 65) b = 8'hF0;
        else if (r < 75) b = ($urandom_range(0, 1) != 0) ? 8'h22 : 8'h1A;
        else if (r < 83) b = selCodes[$urandom_range(0, 4)];
        else if (r < 93) b = ($urandom_range(0, 1) != 0) ? 8'h75 : 8'h72;
        else             b = 8'($urandom);
        applyByte(b);
      end
      compared++; if (note_in !== mNoteIn) begin mismatched++; $display("[TB] FAIL rand_note_in cyc=%0d got=%0b exp=%0b", cyc, note_in, mNoteIn); end
      compared++; if (note !== mNote) begin mismatched++; $display("[TB] FAIL rand_note cyc=%0d got=%0d exp=%0d", cyc, note, mNote); end
      compared++; if (ADSR_selector !== mSel) begin mismatched++; $display("[TB] FAIL rand_sel cyc=%0d got=%0d exp=%0d", cyc, ADSR_selector, mSel); end
      compared++; if (octave_plus_plus !== eOctP) begin mismatched++; $display("[TB] FAIL rand_oct_plus cyc=%0d got=%0b exp=%0b", cyc, octave_plus_plus, eOctP); end
      compared++; if (octave_minus_minus !== eOctM) begin mismatched++; $display("[TB] FAIL rand_oct_minus cyc=%0d got=%0b exp=%0b", cyc, octave_minus_minus, eOctM); end
      compared++; if (ADSR_plus_plus !== eAdP) begin mismatched++; $display("[TB] FAIL rand_adsr_plus cyc=%0d got=%0b exp=%0b", cyc, ADSR_plus_plus, eAdP); end
      compared++; if (ADSR_minus_minus !== eAdM) begin mismatched++; $display("[TB] FAIL rand_adsr_minus cyc=%0d got=%0b exp=%0b", cyc, ADSR_minus_minus, eAdM); end
    end
  endtask

  initial begin
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_error = 1'b0;
    byte_data  = 8'h00;
    modelReset();
    @(negedge clk);
    test_reset();
    test_note_basic();
    test_note_fallback();
    test_octave_repeat();
    test_adsr();
    test_timeout();
    test_error();
    test_reset_mid_sequence();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
